// File: rtl/dram_resp_pkg.sv
// Shared types and address-window decode for the data-memory responder.
// The window check returns an in-range flag plus the word index.
package dram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic        hit;
    logic [31:0] word;
  } win_t;

  // Offset uses a wrap-around subtract, so addresses below the base land far
  // beyond the window and are flagged rather than aliasing onto low words.
  function automatic win_t win_check(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
    logic [31:0] off;
    logic [33:0] lim;
    win_t        w;
    off    = addr - base;
    lim    = 34'(depth) * 34'(WORD_BYTES);
    w.hit  = {2'b00, off} < lim;
    w.word = off >> $clog2(WORD_BYTES);
    return w;
  endfunction

endpackage

// File: rtl/dram_bank.sv
// Word-organised RAM, DEPTH x 32, per-byte write enables, registered read.
// Read data appears after the edge where re is high and holds until the next read.
module dram_bank #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [3:0]               we,
  input  logic [31:0]              wdata,
  input  logic                     re,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dram_responder.sv
// Data-memory responder: one request at a time, accept to rsp_valid takes WAIT_CYCLES+1 edges.
// Backpressure: req_ready is low from accept until the response handshake; response held until rsp_ready.
module dram_responder
  import dram_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        rd_sel_q, rd_sel_d;
  logic        err_q, err_d;

  win_t          win;
  logic [IW-1:0] idx;
  logic          access;
  logic [3:0]    bank_we;
  logic          bank_re;
  logic [31:0]   bank_rdata;
  logic          unused_hi;

  assign win       = win_check(addr_q, BASE_ADDR, DEPTH_WORDS);
  assign idx       = win.word[IW-1:0];
  assign unused_hi = ^win.word[31:IW];
  assign access    = (state_q == WAIT) && (cnt_q == 4'd0);
  assign bank_we   = (access && wen_q && win.hit) ? wmask_q : 4'b0000;
  assign bank_re   = access && !wen_q && win.hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      wen_q    <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wmask_q  <= 4'd0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rd_sel_d = rd_sel_q;
    err_d    = err_q;
    if (state_q == IDLE && req_valid) begin
      wen_d   = req_wen;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      wmask_d = req_wmask;
      cnt_d   = 4'(WAIT_CYCLES);
    end
    if (state_q == WAIT && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    // rd_sel gates the bank's read register so stores and errors return zero.
    if (access) begin
      rd_sel_d = !wen_q && win.hit;
      err_d    = !win.hit;
    end
    if (state_q == RESP && rsp_ready) begin
      rd_sel_d = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rd_sel_q ? bank_rdata : 32'd0;
    rsp_err   = err_q;
  end

  dram_bank #(
    .DEPTH(DEPTH_WORDS)
  ) u_bank (
    .clk  (clk),
    .addr (idx),
    .we   (bank_we),
    .wdata(wdata_q),
    .re   (bank_re),
    .rdata(bank_rdata)
  );

endmodule
